// File: rtl/mcycle_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states,
// instruction field positions and the immediate extension helper.
package mcycle_pkg;

   localparam logic [5:0] OP_NOP   = 6'd0;
   localparam logic [5:0] OP_ADDU  = 6'd1;
   localparam logic [5:0] OP_BEQ   = 6'd2;
   localparam logic [5:0] OP_LW    = 6'd3;
   localparam logic [5:0] OP_MUL   = 6'd4;
   localparam logic [5:0] OP_ADDIU = 6'd5;
   localparam logic [5:0] OP_SW    = 6'd6;
   localparam logic [5:0] OP_J     = 6'd7;
   localparam logic [5:0] OP_JR    = 6'd8;
   localparam logic [5:0] OP_HALT  = 6'd9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int S1_MSB  = 25;
   localparam int S1_LSB  = 21;
   localparam int S2_MSB  = 20;
   localparam int S2_LSB  = 16;
   localparam int D_MSB   = 15;
   localparam int D_LSB   = 11;
   localparam int IMM_MSB = 10;
   localparam int IMM_LSB = 0;
   localparam int TGT_MSB = 9;

   // Sign-magnitude immediate: bit 10 is the sign, bits 9:0 the magnitude.
   // Returned as 32-bit two's complement; callers keep the low DATA_W bits.
   function automatic logic [31:0] imm_ext(input logic [10:0] imm);
      logic [31:0] mag;
      mag = {22'd0, imm[9:0]};
      return imm[10] ? (~mag + 32'd1) : mag;
   endfunction

endpackage

// File: rtl/mcycle_if.sv
// Host/status bundle of the multicycle core. The core takes the slave view,
// the host (or bench) the master view.
interface mcycle_if
   import mcycle_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int IMEM_DEPTH = 32,
   parameter int DMEM_DEPTH = 64
);
   localparam int PC_W = $clog2(IMEM_DEPTH);
   localparam int HA_W = $clog2((IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH);

   logic              start;
   logic              busy;
   logic              halted;
   logic              error;
   logic [PC_W-1:0]   pc;
   logic              host_we;
   logic              host_sel;
   logic [HA_W-1:0]   host_addr;
   logic [31:0]       host_wdata;
   logic [31:0]       host_rdata;
   logic [4:0]        dbg_reg;
   logic [DATA_W-1:0] dbg_data;

   modport master (
      output start, host_we, host_sel, host_addr, host_wdata, dbg_reg,
      input  busy, halted, error, pc, host_rdata, dbg_data
   );

   modport slave (
      input  start, host_we, host_sel, host_addr, host_wdata, dbg_reg,
      output busy, halted, error, pc, host_rdata, dbg_data
   );
endinterface

// File: rtl/mcycle_alu.sv
// Combinational datapath of the core: add, truncated multiply, equality and
// A+imm (shared by ADDIU and the load/store effective address).
module mcycle_alu
   import mcycle_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] imm_i,
   output logic [DATA_W-1:0] sum_ab_o,
   output logic [DATA_W-1:0] prod_o,
   output logic [DATA_W-1:0] ea_o,
   output logic              eq_o
);
   assign sum_ab_o = a_i + b_i;
   assign prod_o   = a_i * b_i;
   assign ea_o     = a_i + imm_i;
   assign eq_o     = (a_i == b_i);
endmodule

// File: rtl/mcycle_cpu.sv
// Multicycle core: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB,
// with host-loadable instruction and data memories.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_FETCH  | IR <- imem[pc]; out-of-range pc faults
// S_DECODE | A, B from register file, immediate extended
// S_EXEC   | ALU op / branch resolution / address check; jumps end here
// S_MEM    | LW reads, SW writes data memory
// S_WB     | register write-back
// S_HALT   | stopped after HALT or fault, waiting for start
module mcycle_cpu
   import mcycle_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NREGS      = 32,
   parameter int IMEM_DEPTH = 32,
   parameter int DMEM_DEPTH = 64
) (
   input logic     clk_i,
   input logic     rst_i,
   mcycle_if.slave bus
);
   localparam int PC_W = $clog2(IMEM_DEPTH);
   localparam int DA_W = $clog2(DMEM_DEPTH);
   localparam int HA_W = $clog2((IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH);

   // The PC is kept DATA_W wide so jumps past the end of imem are caught at FETCH.
   localparam logic [DATA_W-1:0] IMEM_LIM  = DATA_W'(IMEM_DEPTH);
   localparam logic [DATA_W-1:0] DMEM_LIM  = DATA_W'(DMEM_DEPTH);
   localparam logic [HA_W:0]     IMEM_HLIM = (HA_W+1)'(IMEM_DEPTH);
   localparam logic [HA_W:0]     DMEM_HLIM = (HA_W+1)'(DMEM_DEPTH);
   localparam logic [5:0]        NREGS_LIM = 6'(NREGS);

   logic [31:0]       imem [IMEM_DEPTH];
   logic [DATA_W-1:0] dmem [DMEM_DEPTH];
   logic [DATA_W-1:0] regs_q [NREGS];

   state_t            state_q;
   logic [DATA_W-1:0] pc_q;
   logic [31:0]       ir_q;
   logic [DATA_W-1:0] a_q, b_q, imm_q, res_q;
   logic [DA_W-1:0]   daddr_q;
   logic [4:0]        wdst_q;
   logic              busy_q, halted_q, error_q;
   logic [31:0]       host_rdata_q;

   logic [5:0]        op;
   logic [4:0]        s1, s2, dd;
   logic [10:0]       imm_raw;
   logic [31:0]       imm_w;
   logic [DATA_W-1:0] tgt, pc_inc;
   logic [DATA_W-1:0] sum_ab, prod, ea;
   logic              eq;
   logic              mem_fault;
   logic [DA_W-1:0]   daddr;
   logic              host_wr, host_imem_ok, host_dmem_ok;

   assign op      = ir_q[OP_MSB:OP_LSB];
   assign s1      = ir_q[S1_MSB:S1_LSB];
   assign s2      = ir_q[S2_MSB:S2_LSB];
   assign dd      = ir_q[D_MSB:D_LSB];
   assign imm_raw = ir_q[IMM_MSB:IMM_LSB];
   assign imm_w   = imm_ext(imm_raw);
   assign tgt     = DATA_W'(ir_q[TGT_MSB:0]);
   assign pc_inc  = pc_q + DATA_W'(1);

   // Indices at or beyond NREGS and R0 always read as zero.
   function automatic logic [DATA_W-1:0] reg_rd(input logic [4:0] idx);
      if (idx != 5'd0 && {1'b0, idx} < NREGS_LIM) return regs_q[idx];
      return '0;
   endfunction

   mcycle_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .imm_i    (imm_q),
      .sum_ab_o (sum_ab),
      .prod_o   (prod),
      .ea_o     (ea),
      .eq_o     (eq)
   );

   assign mem_fault = (ea[1:0] != 2'b00) || ((ea >> 2) >= DMEM_LIM);
   assign daddr     = ea[DA_W+1:2];

   assign host_wr      = bus.host_we && !busy_q;
   assign host_imem_ok = ({1'b0, bus.host_addr} < IMEM_HLIM);
   assign host_dmem_ok = ({1'b0, bus.host_addr} < DMEM_HLIM);

   // Instruction sequencer, architectural registers and status flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         res_q    <= '0;
         daddr_q  <= '0;
         wdst_q   <= '0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_HALT: begin
               if (bus.start) begin
                  state_q  <= S_FETCH;
                  pc_q     <= '0;
                  busy_q   <= 1'b1;
                  halted_q <= 1'b0;
                  error_q  <= 1'b0;
               end
            end
            S_FETCH: begin
               if (pc_q >= IMEM_LIM) begin
                  state_q  <= S_HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
                  error_q  <= 1'b1;
               end else begin
                  ir_q    <= imem[pc_q[PC_W-1:0]];
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q     <= reg_rd(s1);
               b_q     <= reg_rd(s2);
               imm_q   <= imm_w[DATA_W-1:0];
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               case (op)
                  OP_NOP: begin
                     pc_q    <= pc_inc;
                     state_q <= S_FETCH;
                  end
                  OP_ADDU: begin
                     res_q   <= sum_ab;
                     wdst_q  <= dd;
                     pc_q    <= pc_inc;
                     state_q <= S_WB;
                  end
                  OP_MUL: begin
                     res_q   <= prod;
                     wdst_q  <= dd;
                     pc_q    <= pc_inc;
                     state_q <= S_WB;
                  end
                  OP_ADDIU: begin
                     res_q   <= ea;
                     wdst_q  <= s2;
                     pc_q    <= pc_inc;
                     state_q <= S_WB;
                  end
                  OP_BEQ: begin
                     pc_q    <= eq ? tgt : pc_inc;
                     state_q <= S_FETCH;
                  end
                  OP_J: begin
                     pc_q    <= tgt;
                     state_q <= S_FETCH;
                  end
                  OP_JR: begin
                     pc_q    <= a_q;
                     state_q <= S_FETCH;
                  end
                  OP_LW, OP_SW: begin
                     // A bad address stops here so no memory or register write follows.
                     if (mem_fault) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        error_q  <= 1'b1;
                     end else begin
                        daddr_q <= daddr;
                        wdst_q  <= s2;
                        pc_q    <= pc_inc;
                        state_q <= S_MEM;
                     end
                  end
                  OP_HALT: begin
                     state_q  <= S_HALT;
                     busy_q   <= 1'b0;
                     halted_q <= 1'b1;
                  end
                  default: begin
                     state_q  <= S_HALT;
                     busy_q   <= 1'b0;
                     halted_q <= 1'b1;
                     error_q  <= 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               if (op == OP_LW) begin
                  res_q   <= dmem[daddr_q];
                  state_q <= S_WB;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            S_WB: begin
               if (wdst_q != 5'd0 && {1'b0, wdst_q} < NREGS_LIM) regs_q[wdst_q] <= res_q;
               state_q <= S_FETCH;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Memory arrays: host loads while stopped, SW commits on the MEM edge.
   always_ff @(posedge clk_i) begin
      if (host_wr && !bus.host_sel && host_imem_ok)
         imem[bus.host_addr[PC_W-1:0]] <= bus.host_wdata;
      if (host_wr && bus.host_sel && host_dmem_ok)
         dmem[bus.host_addr[DA_W-1:0]] <= bus.host_wdata[DATA_W-1:0];
      else if (state_q == S_MEM && op == OP_SW)
         dmem[daddr_q] <= b_q;
   end

   // Registered host read port, refreshed every cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         host_rdata_q <= '0;
      else if (bus.host_sel)
         host_rdata_q <= host_dmem_ok ? 32'(dmem[bus.host_addr[DA_W-1:0]]) : '0;
      else
         host_rdata_q <= host_imem_ok ? imem[bus.host_addr[PC_W-1:0]] : '0;
   end

   assign bus.busy       = busy_q;
   assign bus.halted     = halted_q;
   assign bus.error      = error_q;
   assign bus.pc         = pc_q[PC_W-1:0];
   assign bus.host_rdata = host_rdata_q;
   assign bus.dbg_data   = reg_rd(bus.dbg_reg);

endmodule

// File: doc/mcycle_cpu.md
# mcycle_cpu

Parametrised multicycle processor core for the lab's 32-bit custom ISA: op[31:26], s1[25:21], s2[20:16], d[15:11], imm[10:0]. It fetches from an internal instruction memory, decodes, executes, accesses an internal data memory and writes back, one instruction at a time, under a program counter. A host port loads both memories while the core is stopped. The core runs arbitrary programs, such as the dot-product kernel, until HALT or a fault. It is the general successor to the hand-sequenced single-program FSM.

## Interface
- DATA_W, 32: register, ALU and data-memory word width (16..32).
- NREGS, 32: register count (8..32); register indices ≥ NREGS read 0, writes ignored.
- IMEM_DEPTH, 32: instruction words.
- DMEM_DEPTH, 64: data words.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse in IDLE/HALT: PC←0, run.
- busy  out  1  high from FETCH of first instruction until HALT/IDLE.
- halted  out  1  sticky; set on HALT or fault, cleared by start.
- error  out  1  sticky fault flag, valid with halted.
- pc  out  clog2(IMEM_DEPTH)  current PC (word index).
- host_we  in  1  memory write strobe, ignored while busy.
- host_sel  in  1  0 = imem, 1 = dmem.
- host_addr  in  clog2(max depth)  word index.
- host_wdata  in  32  write data (dmem takes low DATA_W bits).
- host_rdata  out  32  registered read of addressed word, 1-cycle latency.
- dbg_reg  in  5  register index.
- dbg_data  out  DATA_W  combinational register value.

## Operation
- States: IDLE → FETCH → DECODE → EXEC → (MEM) → WB → FETCH. HALT is terminal until start.
- FETCH: IR←imem[pc]. pc ≥ IMEM_DEPTH → fault.
- DECODE: A←R[s1], B←R[s2], imm sign-magnitude. Bit 10 is the sign, bits 9:0 the magnitude, extended to DATA_W.
- Opcodes:
  - 0 NOP.
  - 1 ADDU R[d]←A+B.
  - 2 BEQ: if A==B then pc←imm[9:0], else pc+1.
  - 3 LW R[s2]←dmem[(A+imm)>>2].
  - 4 MUL R[d]←(A*B)[DATA_W-1:0].
  - 5 ADDIU R[s2]←A+imm.
  - 6 SW dmem[(A+imm)>>2]←B.
  - 7 J pc←imm[9:0].
  - 8 JR pc←A.
  - 9 HALT.
  - Other opcodes → fault.
- Branch/jump/HALT/NOP finish in EXEC; they skip MEM and WB.
- ADDU/MUL/ADDIU skip MEM. LW/SW use MEM; SW skips WB.
- Addresses are bytes. Effective address bits[1:0]≠0 or index ≥ DMEM_DEPTH → fault; no memory write occurs.
- R0 reads 0 always; writes to R0 are discarded.
- All arithmetic wraps modulo 2^DATA_W. No overflow trap.
- Fault: halted=1, error=1, busy=0. pc holds the faulting instruction's PC. No architectural write for that instruction.
- start while busy is ignored.

## Timing
- Reset: state=IDLE, pc=0, all registers 0, busy=0, halted=0, error=0, host_rdata=0. Memory contents are not reset.
- start sampled high in cycle n → FETCH in n+1, busy=1 in n+1.
- Instruction latency:
  - 3 cycles: branch/jump/NOP/HALT.
  - 4 cycles: ADDU/MUL/ADDIU.
  - 5 cycles: LW.
  - 4 cycles: SW.
- Register write lands on the WB edge and is visible to the next DECODE.
- halted rises the cycle after HALT's EXEC. busy falls the same cycle.
- Host write takes effect on the edge where host_we=1 and busy=0.
- host_rdata is updated every cycle from host_addr/host_sel. It is readable during HALT.
- reset mid-instruction aborts with no partial write committed; everything returns to reset values.

## Structure
- Package mcycle_pkg holds:
  - opcode constants;
  - state enumeration;
  - IR field bit positions;
  - sign-magnitude immediate extension function.
- One sub-module, mcycle_alu: combinational add, multiply, equality and effective address for parametrised DATA_W.
- Register file and memories stay in the core.

## Test plan
- Dot product:
  - Program: ADDIU prelude setting r3=0, r5=12, r7=3, then the addu/beq/lw/lw/mul/addu/addiu×3/j loop ending in HALT.
  - Data: dmem[0..2]=1,2,3 and dmem[3..5]=4,5,6.
  - Required: halted=1, error=0, dbg r1=32, r7=0, r3=12.
- Immediate sign: ADDIU r4,r0,imm=0x401 (−1) → r4=all ones. imm=0x005 → r4=5.
- R0 protection: ADDU r0,r1,r1 with r1=7 → r0 reads 0 afterwards.
- SW then LW round-trip:
  - SW r2=0xA5 at address 8 → host read of dmem[2]=0xA5.
  - LW back into r6 → r6=0xA5.
- Faults:
  - LW at address 6 → error=1, pc points at the LW, destination unchanged.
  - Opcode 0x3F → error=1.
  - Restart with start clears both flags.
- Reset mid-run: assert reset during MEM of an SW → state IDLE, r-file 0, target dmem word unchanged. Host write while busy is ignored.
